// File: rtl/riscv_rf_pkg.sv
// Shared defaults and types for the integer register file and its busy scoreboard.
package riscv_rf_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = reg_addr_t'(0);
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: reserve at issue, release at writeback, flush clears all.
// Also keeps an exact count of busy registers and flags writebacks to unreserved registers.
module rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  input  logic          we3,
  input  logic [AW-1:0] a3,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  input  logic          flush,
  output logic          busy1,
  output logic          busy2,
  output logic          rsv_busy,
  output logic [AW:0]   busy_count,
  output logic          err_wb_unrsv
);
  localparam logic [AW-1:0] ZADDR    = AW'(ZERO_ADDR);
  localparam logic          HAS_ZERO = (ZERO_REG != 0);
  localparam logic          HAS_BYP  = (BYPASS != 0);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             r_err;
  logic             w_wb_valid;
  logic             w_rsv_valid;
  logic             w_set_new;
  logic             w_clr_real;

  assign w_wb_valid  = we3 & ~(HAS_ZERO & (a3 == ZADDR));
  assign w_rsv_valid = rsv_en & ~(HAS_ZERO & (rsv_addr == ZADDR));
  // A release of the register being reserved in the same cycle is not a real clear.
  assign w_set_new   = w_rsv_valid & ~r_busy[rsv_addr];
  assign w_clr_real  = w_wb_valid & r_busy[a3] & ~(w_rsv_valid & (rsv_addr == a3));

  assign busy1    = r_busy[a1] & ~(HAS_BYP & we3 & (a3 == a1)) & ~(HAS_ZERO & (a1 == ZADDR));
  assign busy2    = r_busy[a2] & ~(HAS_BYP & we3 & (a3 == a2)) & ~(HAS_ZERO & (a2 == ZADDR));
  assign rsv_busy = r_busy[rsv_addr] & ~(we3 & (a3 == rsv_addr));

  assign busy_count   = r_count;
  assign err_wb_unrsv = r_err;

  // Next busy vector with priority flush > reserve > release.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NREGS; i++) begin
      if (flush) begin
        w_busy_nxt[i] = 1'b0;
      end else if (w_rsv_valid && (rsv_addr == AW'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if (w_wb_valid && (a3 == AW'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = r_busy[i];
      end
    end
  end

  // Incremental popcount of the busy vector.
  always_comb begin
    case ({w_set_new, w_clr_real})
      2'b10:   w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // Scoreboard state; flush clears busy state but still lets the error flag drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= {NREGS{1'b0}};
      r_count <= {(AW+1){1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= flush ? {(AW+1){1'b0}} : w_count_nxt;
      r_err   <= w_wb_valid & ~r_busy[a3] & ~flush;
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file (2 async reads, 1 write, optional bypass, optional zero register)
// with a busy scoreboard used by decode for RAW/WAW hazard detection.
module regfile_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int AW       = $clog2(NREGS),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we3,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_busy,
  input  logic            flush,
  output logic [AW:0]     busy_count,
  output logic            err_wb_unrsv
);
  localparam logic [AW-1:0] ZADDR    = AW'(ZERO_ADDR);
  localparam logic          HAS_ZERO = (ZERO_REG != 0);
  localparam logic          HAS_BYP  = (BYPASS != 0);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_we;

  assign w_we = we3 & ~(HAS_ZERO & (a3 == ZADDR));

  // Storage array; cleared asynchronously so reads are defined while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else if (w_we) begin
      r_regs[a3] <= wd3;
    end
  end

  // Read port 1: zero register, then same-cycle writeback forwarding, then storage.
  always_comb begin
    if (HAS_ZERO && (a1 == ZADDR)) begin
      rd1 = {XLEN{1'b0}};
    end else if (HAS_BYP && we3 && (a3 == a1)) begin
      rd1 = wd3;
    end else begin
      rd1 = r_regs[a1];
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    if (HAS_ZERO && (a2 == ZADDR)) begin
      rd2 = {XLEN{1'b0}};
    end else if (HAS_BYP && we3 && (a3 == a2)) begin
      rd2 = wd3;
    end else begin
      rd2 = r_regs[a2];
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .a1           (a1),
    .a2           (a2),
    .we3          (we3),
    .a3           (a3),
    .rsv_en       (rsv_en),
    .rsv_addr     (rsv_addr),
    .flush        (flush),
    .busy1        (busy1),
    .busy2        (busy2),
    .rsv_busy     (rsv_busy),
    .busy_count   (busy_count),
    .err_wb_unrsv (err_wb_unrsv)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a randomized
// back-to-back run checked against a reference model through expectation queues.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, we3, rsv_en, flush;
  logic [4:0]  a1, a2, a3, rsv_addr;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy1, busy2, rsv_busy, err_wb_unrsv;
  logic        busy1_nb, busy2_nb, rsv_busy_nb, err_nb;
  logic [5:0]  busy_count, cnt_nb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        rb;
  } comb_exp_t;
  typedef struct {
    logic [5:0] cnt;
    logic       err;
  } seq_exp_t;

  comb_exp_t   comb_q[$];
  seq_exp_t    seq_q[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we3(we3), .a3(a3), .wd3(wd3),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_busy(rsv_busy), .flush(flush),
    .busy_count(busy_count), .err_wb_unrsv(err_wb_unrsv)
  );

  regfile_scoreboard #(.BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1_nb), .rd2(rd2_nb),
    .busy1(busy1_nb), .busy2(busy2_nb), .we3(we3), .a3(a3), .wd3(wd3),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_busy(rsv_busy_nb), .flush(flush),
    .busy_count(cnt_nb), .err_wb_unrsv(err_nb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    a3 = 5'd0; wd3 = 32'd0; rsv_addr = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); a1 = 5'd3; a2 = 5'd31;
    tick(); tick();
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", busy_count); end
    checks++; if (err_wb_unrsv !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_wb_unrsv); end
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h exp 0", rd1); end
    checks++; if (rd2 !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h exp 0", rd2); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    idle(); we3 = 1'b1; a3 = 5'd5; wd3 = 32'h1111_1111;
    tick();
    checks++; if (err_wb_unrsv !== 1'b1) begin errors++; $display("FAIL unrsv_write_err got %b exp 1", err_wb_unrsv); end
    wd3 = 32'hDEAD_BEEF; a1 = 5'd5; a2 = 5'd5;
    #1;
    checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd1 got %h exp deadbeef", rd1); end
    checks++; if (rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rd2 got %h exp deadbeef", rd2); end
    checks++; if (rd1_nb !== 32'h1111_1111) begin errors++; $display("FAIL nobypass_rd1 got %h exp 11111111", rd1_nb); end
    checks++; if (rd2_nb !== 32'h1111_1111) begin errors++; $display("FAIL nobypass_rd2 got %h exp 11111111", rd2_nb); end
    tick(); idle(); #1;
    checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL written_rd1 got %h exp deadbeef", rd1); end
    checks++; if (rd1_nb !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nobypass_written got %h exp deadbeef", rd1_nb); end
  endtask

  task automatic test_zero_reg();
    idle(); we3 = 1'b1; a3 = 5'd0; wd3 = 32'h0000_1234; a1 = 5'd0;
    #1;
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL zero_bypass_rd1 got %h exp 0", rd1); end
    tick();
    checks++; if (err_wb_unrsv !== 1'b0) begin errors++; $display("FAIL zero_write_err got %b exp 0", err_wb_unrsv); end
    idle(); #1;
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL zero_rd1 got %h exp 0", rd1); end
    checks++; if (rd1_nb !== 32'h0000_1234) begin errors++; $display("FAIL nozero_rd1 got %h exp 1234", rd1_nb); end
    rsv_en = 1'b1; rsv_addr = 5'd0;
    tick(); idle(); #1;
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL zero_rsv_count got %0d exp 0", busy_count); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL zero_busy1 got %b exp 0", busy1); end
  endtask

  task automatic test_reserve_release();
    idle(); rsv_en = 1'b1; rsv_addr = 5'd7;
    tick(); idle(); a1 = 5'd7; rsv_addr = 5'd7; #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rsv_busy1 got %b exp 1", busy1); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL rsv_count got %0d exp 1", busy_count); end
    checks++; if (rsv_busy !== 1'b1) begin errors++; $display("FAIL waw_busy got %b exp 1", rsv_busy); end
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'd77; #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL release_busy1 got %b exp 0", busy1); end
    checks++; if (rsv_busy !== 1'b0) begin errors++; $display("FAIL release_waw got %b exp 0", rsv_busy); end
    checks++; if (rd1 !== 32'd77) begin errors++; $display("FAIL release_rd1 got %h exp 4d", rd1); end
    tick(); idle(); #1;
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL release_count got %0d exp 0", busy_count); end
    checks++; if (err_wb_unrsv !== 1'b0) begin errors++; $display("FAIL release_err got %b exp 0", err_wb_unrsv); end
    checks++; if (rd1 !== 32'd77) begin errors++; $display("FAIL release_stored got %h exp 4d", rd1); end
  endtask

  task automatic test_same_edge();
    idle(); rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd9; we3 = 1'b1; a3 = 5'd9; wd3 = 32'd99;
    tick(); idle(); a1 = 5'd9; #1;
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL same_edge_count got %0d exp 1", busy_count); end
    checks++; if (err_wb_unrsv !== 1'b0) begin errors++; $display("FAIL same_edge_err got %b exp 0", err_wb_unrsv); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL same_edge_busy1 got %b exp 1", busy1); end
    checks++; if (rd1 !== 32'd99) begin errors++; $display("FAIL same_edge_rd1 got %h exp 63", rd1); end
    we3 = 1'b1; a3 = 5'd9; wd3 = 32'd154;
    tick(); idle(); #1;
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL same_edge_release got %0d exp 0", busy_count); end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      idle(); rsv_en = 1'b1; rsv_addr = 5'(i);
      tick();
    end
    idle(); #1;
    checks++; if (busy_count !== 6'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", busy_count); end
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd4;
    tick(); idle(); a1 = 5'd4; a2 = 5'd1; #1;
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", busy_count); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL flush_busy_x4 got %b exp 0", busy1); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL flush_busy_x1 got %b exp 0", busy2); end
    we3 = 1'b1; a3 = 5'd4; wd3 = 32'd44;
    tick(); idle(); #1;
    checks++; if (err_wb_unrsv !== 1'b1) begin errors++; $display("FAIL flush_err_pulse got %b exp 1", err_wb_unrsv); end
    checks++; if (rd1 !== 32'd44) begin errors++; $display("FAIL flush_write_rd1 got %h exp 2c", rd1); end
    tick();
    checks++; if (err_wb_unrsv !== 1'b0) begin errors++; $display("FAIL flush_err_end got %b exp 0", err_wb_unrsv); end
  endtask

  task automatic test_reset_midrun();
    idle(); we3 = 1'b1; a3 = 5'd6; wd3 = 32'd66; rsv_en = 1'b1; rsv_addr = 5'd10;
    tick(); idle(); a1 = 5'd5; a2 = 5'd6; #1;
    checks++; if (rd2 !== 32'd66) begin errors++; $display("FAIL midrun_pre_rd2 got %h exp 42", rd2); end
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL midrun_pre_count got %0d exp 1", busy_count); end
    reset = 1'b1; #1;
    checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL midrun_rd1 got %h exp 0", rd1); end
    checks++; if (rd2 !== 32'd0) begin errors++; $display("FAIL midrun_rd2 got %h exp 0", rd2); end
    checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL midrun_count got %0d exp 0", busy_count); end
    checks++; if (err_wb_unrsv !== 1'b0) begin errors++; $display("FAIL midrun_err got %b exp 0", err_wb_unrsv); end
    tick(); reset = 1'b0;
    rsv_en = 1'b1; rsv_addr = 5'd12;
    tick(); idle(); #1;
    checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL post_reset_count got %0d exp 1", busy_count); end
  endtask

  task automatic test_back_to_back();
    comb_exp_t ce, ca;
    seq_exp_t  se, sa;
    logic      wb_v, rv_v;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_busy = 32'd0;
    m_busy[12] = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a1 = 5'($urandom_range(0, 15)); a2 = 5'($urandom_range(0, 15));
      we3 = 1'($urandom_range(0, 1)); a3 = 5'($urandom_range(0, 15)); wd3 = $urandom;
      rsv_en = 1'($urandom_range(0, 1)); rsv_addr = 5'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      ce.rd1 = (a1 == 5'd0) ? 32'd0 : ((we3 && a3 == a1) ? wd3 : m_regs[a1]);
      ce.rd2 = (a2 == 5'd0) ? 32'd0 : ((we3 && a3 == a2) ? wd3 : m_regs[a2]);
      ce.b1  = (a1 != 5'd0) && m_busy[a1] && !(we3 && a3 == a1);
      ce.b2  = (a2 != 5'd0) && m_busy[a2] && !(we3 && a3 == a2);
      ce.rb  = m_busy[rsv_addr] && !(we3 && a3 == rsv_addr);
      comb_q.push_back(ce);
      wb_v = we3 && (a3 != 5'd0);
      rv_v = rsv_en && (rsv_addr != 5'd0);
      se.err = wb_v && !m_busy[a3] && !flush;
      if (wb_v) m_regs[a3] = wd3;
      if (flush) m_busy = 32'd0;
      else begin
        if (wb_v) m_busy[a3] = 1'b0;
        if (rv_v) m_busy[rsv_addr] = 1'b1;
      end
      se.cnt = 6'($countones(m_busy));
      seq_q.push_back(se);
      #1;
      ca = comb_q.pop_front();
      checks++; if (rd1 !== ca.rd1) begin errors++; $display("FAIL rand_rd1 n=%0d got %h exp %h", n, rd1, ca.rd1); end
      checks++; if (rd2 !== ca.rd2) begin errors++; $display("FAIL rand_rd2 n=%0d got %h exp %h", n, rd2, ca.rd2); end
      checks++; if (busy1 !== ca.b1) begin errors++; $display("FAIL rand_busy1 n=%0d got %b exp %b", n, busy1, ca.b1); end
      checks++; if (busy2 !== ca.b2) begin errors++; $display("FAIL rand_busy2 n=%0d got %b exp %b", n, busy2, ca.b2); end
      checks++; if (rsv_busy !== ca.rb) begin errors++; $display("FAIL rand_rsv_busy n=%0d got %b exp %b", n, rsv_busy, ca.rb); end
      tick();
      sa = seq_q.pop_front();
      checks++; if (busy_count !== sa.cnt) begin errors++; $display("FAIL rand_count n=%0d got %0d exp %0d", n, busy_count, sa.cnt); end
      checks++; if (err_wb_unrsv !== sa.err) begin errors++; $display("FAIL rand_err n=%0d got %b exp %b", n, err_wb_unrsv, sa.err); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_reserve_release();
    test_same_edge();
    test_flush();
    test_reset_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
